// File: rtl/winograd_dot8.sv
// Two-stage Winograd pair-product core: pre-add, multiply, pairwise add.
// WINOGRAD_INPUT_REG_EN adds an input register stage (latency 3).
module winograd_dot8 #(
  parameter  int IN_SIZE_0 = 8,
  parameter  int IN_SIZE_1 = 8,
  localparam int OUT_SIZE  = 2*(IN_SIZE_1+1)+6
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0][IN_SIZE_0-1:0]     in_0_i,
  input  logic [7:0][IN_SIZE_1-1:0]     in_1_i,
  output logic [1:0][OUT_SIZE-1:0]      out_o
);

  localparam int EW = IN_SIZE_1 + 1;
  localparam int PW = 2 * EW;

  logic [7:0][IN_SIZE_0-1:0] a;
  logic [7:0][IN_SIZE_1-1:0] b;

`ifdef WINOGRAD_INPUT_REG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a <= '0;
      b <= '0;
    end else begin
      a <= in_0_i;
      b <= in_1_i;
    end
  end
`else
  assign a = in_0_i;
  assign b = in_1_i;
`endif

  logic signed [EW-1:0] s [4];
  logic signed [EW-1:0] t [4];
  logic signed [PW-1:0] p_d [4];
  logic signed [PW-1:0] p_q [4];

  // A lanes are no wider than B, so EW bits hold either sum exactly
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s[k]   = EW'($signed(a[2*k+1])) + EW'($signed(b[2*k]));
      t[k]   = EW'($signed(a[2*k]))   + EW'($signed(b[2*k+1]));
      p_d[k] = PW'(s[k]) * PW'(t[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 4; k++) p_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) p_q[k] <= p_d[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_o <= '0;
    end else begin
      out_o[0] <= OUT_SIZE'(p_q[0]) + OUT_SIZE'(p_q[1]);
      out_o[1] <= OUT_SIZE'(p_q[2]) + OUT_SIZE'(p_q[3]);
    end
  end

endmodule

// File: tb/tb_winograd_dot8.sv
// Directed and random checks for winograd_dot8 at default widths.
// Honours WINOGRAD_INPUT_REG_EN for the expected latency.
module tb_winograd_dot8;

`ifdef WINOGRAD_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NR = 100;

  logic             clk;
  logic             rst_n;
  logic [7:0][7:0]  in_0;
  logic [7:0][7:0]  in_1;
  logic [1:0][23:0] out;

  int n_chk;
  int n_pass;

  logic [7:0][7:0] ra [NR];
  logic [7:0][7:0] rb [NR];
  longint          gold [NR];

  winograd_dot8 dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .in_0_i (in_0),
    .in_1_i (in_1),
    .out_o  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint o0();
    return longint'($signed(out[0]));
  endfunction

  function automatic longint o1();
    return longint'($signed(out[1]));
  endfunction

  function automatic longint gold_of(input logic [7:0][7:0] a,
                                     input logic [7:0][7:0] b);
    longint acc;
    longint s;
    longint t;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      s = longint'($signed(a[2*k+1])) + longint'($signed(b[2*k]));
      t = longint'($signed(a[2*k]))   + longint'($signed(b[2*k+1]));
      acc += s * t;
    end
    return acc;
  endfunction

  task automatic fill(input logic [7:0] av, input logic [7:0] bv);
    for (int j = 0; j < 8; j++) begin
      in_0[j] = av;
      in_1[j] = bv;
    end
  endtask

  task automatic directed(input string tag, input logic [7:0] av,
                          input logic [7:0] bv, input longint half);
    @(negedge clk);
    fill(av, bv);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk({tag, "_o0"}, o0(), half);
    chk({tag, "_o1"}, o1(), half);
    chk({tag, "_sum"}, o0() + o1(), 2 * half);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    fill(8'd127, 8'd127);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o0", o0(), 0);
    chk("rst_o1", o1(), 0);

    // pipeline fill after release: zero until LAT edges have passed
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT-1) @(posedge clk);
    #1;
    chk("fill_o0", o0(), 0);
    @(posedge clk);
    #1;
    chk("fill_o0_valid", o0(), 129032);

    directed("maxmax", 8'd127, 8'h80, 2);
    directed("pp",     8'd127, 8'd127, 129032);
    directed("nn",     8'h80,  8'h80,  131072);
    directed("pn",     8'd127, 8'h80,  2);
    directed("np",     8'h80,  8'd127, 2);
    directed("zero",   8'd0,   8'd0,   0);

    // asynchronous reset mid-stream
    directed("pp2", 8'd127, 8'd127, 129032);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o0", o0(), 0);
    chk("arst_o1", o1(), 0);
    @(negedge clk);
    fill(8'd0, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_o0", o0(), 0);
    chk("post_rst_o1", o1(), 0);

    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < 8; j++) begin
        ra[i][j] = 8'($urandom);
        rb[i][j] = 8'($urandom);
      end
      gold[i] = gold_of(ra[i], rb[i]);
    end

    // back-to-back vectors, one per cycle
    for (int i = 0; i < NR + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) chk($sformatf("rnd%0d", i - LAT), o0() + o1(), gold[i-LAT]);
      if (i < NR) begin
        in_0 = ra[i];
        in_1 = rb[i];
      end else begin
        fill(8'd0, 8'd0);
      end
    end

    // held input stays stable
    fill(8'h80, 8'h80);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("hold_a", o0() + o1(), 262144);
    @(posedge clk);
    #1;
    chk("hold_b", o0() + o1(), 262144);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
